// File: rtl/clkscale_seq_pkg.sv
// Shared types and defaults for the clock-scale sequencer.
package clkscale_seq_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    localparam int unsigned NSEG_DEF  = 4;
    localparam int unsigned SW_DEF    = 32;
    localparam int unsigned CW_DEF    = 16;
    localparam int unsigned COUNT_END = 0;

endpackage

// File: rtl/clkscale_seq_if.sv
// Table-write, control and status bundle of the clock-scale sequencer.
interface clkscale_seq_if
    import clkscale_seq_pkg::*;
#(
    parameter int unsigned NSEG = NSEG_DEF,
    parameter int unsigned SW   = SW_DEF,
    parameter int unsigned CW   = CW_DEF
) ();

    localparam int unsigned IW = $clog2(NSEG);

    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [SW-1:0] wr_scale;
    logic [CW-1:0] wr_count;
    logic          start;
    logic          stop;
    logic          loop;
    logic [SW-1:0] clkscale;
    logic          tick;
    logic [IW-1:0] seg;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_idx, wr_scale, wr_count, start, stop, loop,
        input  clkscale, tick, seg, busy, done
    );

    modport slave (
        input  wr_en, wr_idx, wr_scale, wr_count, start, stop, loop,
        output clkscale, tick, seg, busy, done
    );

endinterface

// File: rtl/clkscale_seq_rate_tick.sv
// Divider counter producing a single-cycle enable every max(period,1) enabled cycles.
module clkscale_seq_rate_tick #(
    parameter int unsigned SW = 32
) (
    input  logic          CCLK,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [SW-1:0] period,
    output logic          tick
);

    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_inc;
    logic [SW-1:0] limit;

    // cnt_q never exceeds period-1, so the increment cannot wrap.
    assign limit   = (period == '0) ? SW'(1) : period;
    assign cnt_inc = cnt_q + SW'(1);
    assign tick    = en && (cnt_inc >= limit);

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_inc;
        end
    end

endmodule

// File: rtl/clkscale_seq.sv
// Segment-table scheduler: plays (scale, tick-count) segments in order and
// drives clkscale plus a matching tick enable.
module clkscale_seq
    import clkscale_seq_pkg::*;
#(
    parameter int unsigned NSEG = NSEG_DEF,
    parameter int unsigned SW   = SW_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input logic           CCLK,
    input logic           rst,
    clkscale_seq_if.slave bus
);

    localparam int unsigned   IW   = $clog2(NSEG);
    localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

    state_e        st_q, st_d;
    logic [SW-1:0] scale_tbl [NSEG];
    logic [CW-1:0] count_tbl [NSEG];
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] seg_q, seg_d;
    logic [SW-1:0] clkscale_q, clkscale_d;
    logic [CW-1:0] left_q, left_d;
    logic          done_q, done_d;
    logic          rt_tick;
    logic          go_idle;

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NSEG); i++) begin
                scale_tbl[i] <= '0;
                count_tbl[i] <= '0;
            end
        end else if (bus.wr_en && st_q == StIdle) begin
            scale_tbl[bus.wr_idx] <= bus.wr_scale;
            count_tbl[bus.wr_idx] <= bus.wr_count;
        end
    end

    clkscale_seq_rate_tick #(
        .SW (SW)
    ) u_rate_tick (
        .CCLK   (CCLK),
        .rst    (rst),
        .clr    (st_q != StRun),
        .en     (st_q == StRun),
        .period (clkscale_q),
        .tick   (rt_tick)
    );

    always_comb begin
        st_d       = st_q;
        idx_d      = idx_q;
        seg_d      = seg_q;
        clkscale_d = clkscale_q;
        left_d     = left_q;
        done_d     = 1'b0;
        go_idle    = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    st_d  = StLoad;
                    idx_d = '0;
                end
            end
            StLoad: begin
                if (bus.stop) begin
                    go_idle = 1'b1;
                end else if (count_tbl[idx_q] == CW'(COUNT_END)) begin
                    if (idx_q == '0 || !bus.loop) begin
                        go_idle = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = '0;
                    end
                end else begin
                    clkscale_d = scale_tbl[idx_q];
                    left_d     = count_tbl[idx_q];
                    seg_d      = idx_q;
                    st_d       = StRun;
                end
            end
            StRun: begin
                // stop outranks a coincident tick or segment advance
                if (bus.stop) begin
                    go_idle = 1'b1;
                end else if (rt_tick) begin
                    left_d = left_q - CW'(1);
                    if (left_q == CW'(1)) begin
                        if (idx_q != LAST) begin
                            idx_d = idx_q + IW'(1);
                            st_d  = StLoad;
                        end else if (bus.loop) begin
                            idx_d = '0;
                            st_d  = StLoad;
                        end else begin
                            go_idle = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase
        if (go_idle) begin
            st_d       = StIdle;
            idx_d      = '0;
            seg_d      = '0;
            clkscale_d = '0;
            left_d     = '0;
        end
    end

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            st_q       <= StIdle;
            idx_q      <= '0;
            seg_q      <= '0;
            clkscale_q <= '0;
            left_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            clkscale_q <= clkscale_d;
            left_q     <= left_d;
            done_q     <= done_d;
        end
    end

    assign bus.clkscale = clkscale_q;
    assign bus.seg      = seg_q;
    assign bus.busy     = (st_q != StIdle);
    assign bus.done     = done_q;
    assign bus.tick     = rt_tick && !bus.stop;

endmodule

// File: tb/tb_clkscale_seq.sv
// Directed bench for clkscale_seq: a trace model expands each started program
// into per-cycle expected outputs, checked on every falling edge.
module tb_clkscale_seq;
    import clkscale_seq_pkg::*;

    localparam int unsigned NSEG = 4;
    localparam int unsigned SW   = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned IW   = 2;
    localparam int          NPASS = 3;

    logic CCLK = 1'b0;
    logic rst;
    always #5 CCLK = ~CCLK;

    clkscale_seq_if #(.NSEG(NSEG), .SW(SW), .CW(CW)) bus ();

    clkscale_seq #(.NSEG(NSEG), .SW(SW), .CW(CW)) dut (
        .CCLK (CCLK),
        .rst  (rst),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [SW-1:0] cs;
        logic          tk;
        logic [IW-1:0] sg;
        logic          bz;
        logic          dn;
    } exp_t;

    exp_t q[$];
    int unsigned m_scale [NSEG];
    int unsigned m_count [NSEG];
    int vecs = 0, errs = 0, ticks_seen = 0, dones_seen = 0, last_len = 0;

    task automatic check(input string name, input longint act, input longint req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic void push(input int cs, input bit tk, input int sg, input bit bz,
                                 input bit dn);
        exp_t e;
        e.cs = SW'(cs);
        e.tk = tk;
        e.sg = IW'(sg);
        e.bz = bz;
        e.dn = dn;
        q.push_back(e);
    endfunction

    // Expands the program: one LOAD cycle per segment, scale*count RUN cycles
    // with a tick every max(scale,1) cycles, then a done cycle or a wrap.
    function automatic void build(input bit lp);
        int pcs = 0, psg = 0, k = 0, pass = 0, p;
        while (pass < NPASS) begin
            push(pcs, 1'b0, psg, 1'b1, 1'b0);
            if (m_count[k] == 0) begin
                if (k == 0 || !lp) begin
                    push(0, 1'b0, 0, 1'b0, 1'b1);
                    break;
                end
                pass++;
                k = 0;
            end else begin
                p = (m_scale[k] == 0) ? 1 : int'(m_scale[k]);
                for (int c = 1; c <= p * int'(m_count[k]); c++)
                    push(int'(m_scale[k]), (c % p) == 0, k, 1'b1, 1'b0);
                pcs = int'(m_scale[k]);
                psg = k;
                if (k == int'(NSEG) - 1) begin
                    if (!lp) begin
                        push(0, 1'b0, 0, 1'b0, 1'b1);
                        break;
                    end
                    pass++;
                    k = 0;
                end else begin
                    k++;
                end
            end
        end
        last_len = q.size();
    endfunction

    always @(negedge CCLK) begin
        exp_t e, got;
        if (rst) begin
            q.delete();
            for (int i = 0; i < int'(NSEG); i++) begin
                m_scale[i] = 0;
                m_count[i] = 0;
            end
        end
        e = (q.size() != 0) ? q.pop_front() : '0;
        if (e.bz && bus.stop) begin
            e.tk = 1'b0;
            q.delete();
        end
        got = {bus.clkscale, bus.tick, bus.seg, bus.busy, bus.done};
        vecs++;
        if (got !== e) begin
            errs++;
            $display("FAIL cycle @%0t: got cs=%0d tick=%b seg=%0d busy=%b done=%b, want cs=%0d tick=%b seg=%0d busy=%b done=%b",
                     $time, got.cs, got.tk, got.sg, got.bz, got.dn,
                     e.cs, e.tk, e.sg, e.bz, e.dn);
        end
        if (bus.tick === 1'b1) ticks_seen++;
        if (bus.done === 1'b1) dones_seen++;
        if (!rst && !e.bz) begin
            if (bus.wr_en) begin
                m_scale[bus.wr_idx] = bus.wr_scale;
                m_count[bus.wr_idx] = bus.wr_count;
            end
            if (q.size() == 0 && bus.start && !bus.stop) build(bus.loop);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    task automatic wr(input int idx, input int scale, input int count);
        bus.wr_en    = 1'b1;
        bus.wr_idx   = IW'(idx);
        bus.wr_scale = SW'(scale);
        bus.wr_count = CW'(count);
        cyc(1);
        bus.wr_en    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 500; i++) begin
            if (q.size() == 0 && bus.busy !== 1'b1) break;
            cyc(1);
        end
        check(name, longint'(bus.busy), 0);
        cyc(1);
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_scale = '0; bus.wr_count = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_clkscale", longint'(bus.clkscale), 0);

        // empty program: one LOAD cycle, then done
        pulse_start();
        check("empty_load_busy", longint'(bus.busy), 1);
        cyc(1);
        check("empty_done", longint'(bus.done), 1);
        check("empty_model_len", last_len, 2);
        cyc(2);

        // two-segment program, no loop
        wr(0, 3, 2); wr(1, 5, 1); wr(2, 7, 0);
        ticks_seen = 0; dones_seen = 0;
        pulse_start();
        wait_idle("prog_idle");
        check("prog_model_len", last_len, 15);
        check("prog_ticks", ticks_seen, 3);
        check("prog_dones", dones_seen, 1);
        check("prog_seg_end", longint'(bus.seg), 0);

        // looping: stop late in the third pass
        bus.loop = 1'b1;
        ticks_seen = 0; dones_seen = 0;
        pulse_start();
        cyc(38);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        check("loop_model_len", last_len, 42);
        check("loop_stop_busy", longint'(bus.busy), 0);
        check("loop_ticks", ticks_seen, 8);
        check("loop_dones", dones_seen, 0);
        cyc(2);

        // stop coincident with the final tick of segment 0
        dones_seen = 0;
        pulse_start();
        cyc(6);
        bus.stop = 1'b1;
        #1;
        check("stop_tick_masked", longint'(bus.tick), 0);
        cyc(1);
        bus.stop = 1'b0;
        check("stop_busy", longint'(bus.busy), 0);
        check("stop_clkscale", longint'(bus.clkscale), 0);
        cyc(2);
        check("stop_dones", dones_seen, 0);

        // start with stop in IDLE is refused
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("startstop_busy", longint'(bus.busy), 0);
        cyc(2);

        // write while busy is dropped; next run still uses old entry 1
        pulse_start();
        cyc(2);
        wr(1, 9, 2);
        wait_idle("busywr_idle");
        ticks_seen = 0;
        pulse_start();
        wait_idle("busywr_rerun_idle");
        check("busywr_ticks", ticks_seen, 3);

        // scale 0 and scale 1 both tick every RUN cycle
        wr(0, 0, 4); wr(1, 1, 4); wr(2, 0, 0);
        ticks_seen = 0;
        pulse_start();
        cyc(1);
        check("scale0_first_tick", longint'(bus.tick), 1);
        wait_idle("scale01_idle");
        check("scale01_model_len", last_len, 12);
        check("scale01_ticks", ticks_seen, 8);

        // asynchronous reset in the middle of RUN
        wr(0, 6, 3);
        pulse_start();
        cyc(3);
        check("midrun_busy", longint'(bus.busy), 1);
        check("midrun_clkscale", longint'(bus.clkscale), 6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_clkscale", longint'(bus.clkscale), 0);
        check("arst_busy", longint'(bus.busy), 0);
        check("arst_tick", longint'(bus.tick), 0);
        check("arst_seg", longint'(bus.seg), 0);
        check("arst_done", longint'(bus.done), 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // table was cleared by reset: empty program again
        pulse_start();
        cyc(1);
        check("post_rst_done", longint'(bus.done), 1);
        check("post_rst_model_len", last_len, 2);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
